// File: rtl/axi_res_pkg.sv
// Shared types for the LR/SC reservation path: table command opcodes and
// the scheduler state encoding, used by the scheduler, the table and the adapters.
package axi_res_pkg;

    typedef enum logic [1:0] {
        SET   = 2'b00,
        CHECK = 2'b01,
        CLR   = 2'b10
    } res_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ISSUE    = 2'b01,
        WAIT_RSP = 2'b10
    } res_state_t;

    // Index width that stays at least one bit wide for single-port builds.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_res_rr_pick.sv
// Round-robin selector: first set bit of (req & mask) scanning upward from ptr
// with wrap-around; ptr = 0 turns it into a lowest-index-first priority pick.
module axi_res_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [N-1:0] cand;

    always_comb begin
        int unsigned j;
        cand  = req & mask;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < int'(N); k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && cand[j[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_res_sched.sv
// Arbitrates LR/SC adapter commands onto one reservation table port, one
// command outstanding at a time, with CLR priority and starvation escape.
module axi_res_sched
    import axi_res_pkg::*;
#(
    parameter int unsigned N_PORTS        = 2,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned STARVE_MAX     = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [N_PORTS-1:0]                       req_valid_i,
    input  logic [2*N_PORTS-1:0]                     req_op_i,
    input  logic [AXI_ADDR_WIDTH*N_PORTS-1:0]        req_addr_i,
    input  logic [AXI_ID_WIDTH*N_PORTS-1:0]          req_id_i,
    output logic [N_PORTS-1:0]                       req_ready_o,
    output logic                                     rsp_res_o,
    output logic                                     tbl_valid_o,
    input  logic                                     tbl_ready_i,
    output logic [1:0]                               tbl_op_o,
    output logic [AXI_ADDR_WIDTH-1:0]                tbl_addr_o,
    output logic [AXI_ID_WIDTH+$clog2(N_PORTS)-1:0]  tbl_id_o,
    input  logic                                     tbl_rsp_valid_i,
    input  logic                                     tbl_res_i,
    output res_state_t                               dbg_state_o
);

    localparam int unsigned IDX_W = idx_width(N_PORTS);
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    // Handshake: a requester holds valid/op/addr/id until req_ready_o pulses;
    // the table command is held while tbl_valid_o && !tbl_ready_i.
    res_state_t                state_q, state_d;
    logic [IDX_W-1:0]          g_q, g_d, ptr_q, ptr_d;
    logic [CNT_W-1:0]          cnt_q [N_PORTS];
    logic [N_PORTS-1:0]        clr_req, sc_req, starved, pick_mask;
    logic [IDX_W-1:0]          pick_ptr, win;
    logic                      win_found, arb;
    res_op_t                   op_g;
    logic [AXI_ADDR_WIDTH-1:0] addr_g;
    logic [AXI_ID_WIDTH-1:0]   id_g;

    always_comb begin
        clr_req = '0;
        sc_req  = '0;
        starved = '0;
        op_g    = SET;
        addr_g  = '0;
        id_g    = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            clr_req[i] = req_valid_i[i] && (req_op_i[2*i +: 2] == CLR);
            sc_req[i]  = req_valid_i[i] && (req_op_i[2*i +: 2] != CLR);
            starved[i] = sc_req[i] && (cnt_q[i] == CNT_W'(STARVE_MAX));
            if (IDX_W'(i) == g_q) begin
                op_g   = res_op_t'(req_op_i[2*i +: 2]);
                addr_g = req_addr_i[AXI_ADDR_WIDTH*i +: AXI_ADDR_WIDTH];
                id_g   = req_id_i[AXI_ID_WIDTH*i +: AXI_ID_WIDTH];
            end
        end
    end

    // Starved SET/CHECK beats CLR (lowest index first); otherwise CLR class first.
    assign pick_mask = (|starved) ? starved : ((|clr_req) ? clr_req : sc_req);
    assign pick_ptr  = (|starved) ? '0 : ptr_q;

    axi_res_rr_pick #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid_i),
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .idx   (win),
        .found (win_found)
    );

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        arb         = 1'b0;
        tbl_valid_o = 1'b0;
        req_ready_o = '0;
        rsp_res_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    arb     = 1'b1;
                    g_d     = win;
                    ptr_d   = (win == IDX_W'(N_PORTS - 1)) ? '0 : win + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tbl_valid_o = 1'b1;
                if (tbl_ready_i) begin
                    if (op_g == CHECK) begin
                        state_d = WAIT_RSP;
                    end else begin
                        req_ready_o[g_q] = 1'b1;
                        state_d          = IDLE;
                    end
                end
            end
            WAIT_RSP: begin
                if (tbl_rsp_valid_i) begin
                    req_ready_o[g_q] = 1'b1;
                    rsp_res_o        = tbl_res_i;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tbl_op_o   = tbl_valid_o ? op_g : 2'b00;
    assign tbl_addr_o = tbl_valid_o ? addr_g : '0;

    generate
        if (N_PORTS > 1) begin : g_id_idx
            assign tbl_id_o = tbl_valid_o ? {g_q, id_g} : '0;
        end else begin : g_id_noidx
            assign tbl_id_o = tbl_valid_o ? id_g : '0;
        end
    endgenerate

    assign dbg_state_o = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
        end
    end

    // Counters move only on an arbitration: losers with SET/CHECK age, winner resets.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N_PORTS); i++) cnt_q[i] <= '0;
        end else if (arb) begin
            for (int i = 0; i < int'(N_PORTS); i++) begin
                if (IDX_W'(i) == win) begin
                    cnt_q[i] <= '0;
                end else if (sc_req[i] && (cnt_q[i] != CNT_W'(STARVE_MAX))) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_res_sched.sv
// Directed bench for axi_res_sched: reset, CHECK round trip, CLR priority,
// starvation escape, table stall, reset in WAIT_RSP and spurious responses.
module tb_axi_res_sched;
    import axi_res_pkg::*;

    localparam int NP = 2;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int SM = 4;
    localparam int TW = IW + $clog2(NP);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   req_valid;
    logic [2*NP-1:0] req_op;
    logic [AW*NP-1:0] req_addr;
    logic [IW*NP-1:0] req_id;
    logic [NP-1:0]   req_ready;
    logic            rsp_res;
    logic            tbl_valid;
    logic            tbl_ready;
    logic [1:0]      tbl_op;
    logic [AW-1:0]   tbl_addr;
    logic [TW-1:0]   tbl_id;
    logic            tbl_rsp_valid;
    logic            tbl_res;
    res_state_t      dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    logic [1:0] exp_q[$];

    axi_res_sched #(
        .N_PORTS        (NP),
        .AXI_ADDR_WIDTH (AW),
        .AXI_ID_WIDTH   (IW),
        .STARVE_MAX     (SM)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_op_i        (req_op),
        .req_addr_i      (req_addr),
        .req_id_i        (req_id),
        .req_ready_o     (req_ready),
        .rsp_res_o       (rsp_res),
        .tbl_valid_o     (tbl_valid),
        .tbl_ready_i     (tbl_ready),
        .tbl_op_o        (tbl_op),
        .tbl_addr_o      (tbl_addr),
        .tbl_id_o        (tbl_id),
        .tbl_rsp_valid_i (tbl_rsp_valid),
        .tbl_res_i       (tbl_res),
        .dbg_state_o     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic [1:0] op,
                         input logic [AW-1:0] addr, input logic [IW-1:0] id);
        req_valid[p]         = v;
        req_op[2*p +: 2]     = op;
        req_addr[AW*p +: AW] = addr;
        req_id[IW*p +: IW]   = id;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_op        = '0;
        req_addr      = '0;
        req_id        = '0;
        tbl_ready     = 1'b0;
        tbl_rsp_valid = 1'b0;
        tbl_res       = 1'b0;

        // reset state
        repeat (3) cyc();
        @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_outs", {req_ready, rsp_res, tbl_valid, tbl_op, tbl_addr, tbl_id}, '0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // single CHECK from port0
        drive(0, 1'b1, CHECK, 64'h100, 4'd3);
        tbl_ready = 1'b1;
        @(negedge clk);
        check("t1_idle_quiet", {req_ready, rsp_res, tbl_valid}, '0);
        cyc();
        @(negedge clk);
        check("t1_issue_st", dbg_state, ISSUE);
        check("t1_issue_cmd", {tbl_valid, tbl_op, tbl_addr, tbl_id}, {1'b1, 2'b01, 64'h100, 5'h03});
        check("t1_issue_rdy", req_ready, 2'b00);
        cyc();
        @(negedge clk);
        check("t1_wait_st", dbg_state, WAIT_RSP);
        check("t1_wait_quiet", {req_ready, tbl_valid}, '0);
        cyc();
        tbl_rsp_valid = 1'b1;
        tbl_res       = 1'b1;
        @(negedge clk);
        check("t1_ack", {req_ready, rsp_res}, {2'b01, 1'b1});
        cyc();
        drive(0, 1'b0, SET, '0, '0);
        tbl_rsp_valid = 1'b0;
        tbl_res       = 1'b0;
        @(negedge clk);
        check("t1_back_idle", {dbg_state, req_ready, rsp_res}, {IDLE, 2'b00, 1'b0});

        // SET on port0 and CLR on port1 together: CLR first
        cyc();
        drive(0, 1'b1, SET, 64'h200, 4'd1);
        drive(1, 1'b1, CLR, 64'h300, 4'd2);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        cyc();
        @(negedge clk);
        check("t2_clr_cmd", {tbl_valid, tbl_op, tbl_addr, tbl_id}, {1'b1, 2'b10, 64'h300, 5'h12});
        check("t2_grant1", req_ready, exp_q.pop_front());
        check("t2_cnt0", dut.cnt_q[0], 1);
        cyc();
        drive(1, 1'b0, SET, '0, '0);
        cyc();
        @(negedge clk);
        check("t2_set_cmd", {tbl_valid, tbl_op, tbl_addr, tbl_id}, {1'b1, 2'b00, 64'h200, 5'h01});
        check("t2_grant2", req_ready, exp_q.pop_front());
        check("t2_cnt0_clr", dut.cnt_q[0], 0);

        // back-to-back CLRs on port1 vs held SET on port0
        cyc();
        drive(0, 1'b1, SET, 64'h250, 4'd6);
        drive(1, 1'b1, CLR, 64'h400, 4'd9);
        for (int k = 1; k <= SM + 1; k++) begin
            if (k == SM + 1) begin
                @(negedge clk);
                check("t3_cnt0_sat", dut.cnt_q[0], SM);
            end
            cyc();
            @(negedge clk);
            check($sformatf("t3_arb%0d", k), req_ready, (k <= SM) ? 2'b10 : 2'b01);
            cyc();
            drive(1, 1'b1, CLR, 64'h400 + 64'(k), 4'd9);
        end
        drive(0, 1'b0, SET, '0, '0);
        drive(1, 1'b0, SET, '0, '0);
        cyc();

        // table stall for 10 cycles
        tbl_ready = 1'b0;
        drive(0, 1'b1, SET, 64'hABC, 4'd5);
        cyc();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("t4_stall%0d", k), {tbl_valid, tbl_op, tbl_addr, tbl_id, req_ready},
                  {1'b1, 2'b00, 64'hABC, 5'h05, 2'b00});
            cyc();
        end
        tbl_ready = 1'b1;
        @(negedge clk);
        check("t4_release", req_ready, 2'b01);
        cyc();
        drive(0, 1'b0, SET, '0, '0);
        cyc();

        // reset while in WAIT_RSP
        drive(0, 1'b1, CHECK, 64'h180, 4'd4);
        cyc();
        cyc();
        @(negedge clk);
        check("t5_in_wait", dbg_state, WAIT_RSP);
        cyc();
        tbl_rsp_valid = 1'b1;
        tbl_res       = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_outs", {req_ready, rsp_res, tbl_valid, tbl_op, tbl_addr, tbl_id}, '0);
        check("t5_async_st", dbg_state, IDLE);
        drive(0, 1'b0, SET, '0, '0);
        tbl_rsp_valid = 1'b0;
        tbl_res       = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        drive(1, 1'b1, CHECK, 64'h500, 4'd7);
        cyc();
        @(negedge clk);
        check("t5_p1_cmd", {tbl_valid, tbl_op, tbl_addr, tbl_id}, {1'b1, 2'b01, 64'h500, 5'h17});
        cyc();
        tbl_rsp_valid = 1'b1;
        tbl_res       = 1'b0;
        @(negedge clk);
        check("t5_p1_ack", {req_ready, rsp_res}, {2'b10, 1'b0});
        cyc();
        drive(1, 1'b0, SET, '0, '0);
        tbl_rsp_valid = 1'b0;
        cyc();

        // spurious table response while idle
        tbl_rsp_valid = 1'b1;
        tbl_res       = 1'b1;
        @(negedge clk);
        check("t6_spur_outs", {req_ready, rsp_res, tbl_valid}, '0);
        cyc();
        @(negedge clk);
        check("t6_spur_st", dbg_state, IDLE);
        tbl_rsp_valid = 1'b0;
        tbl_res       = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_res_sched.md
AXI_RES_SCHED -- requirements
Module: axi_res_sched

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of LR/SC adapters sharing one reservation table (legal range 1..16).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, AXI ID width per requester.
REQ-004 SHALL have parameter STARVE_MAX, default 4, number of lost arbitrations after which a SET/CHECK request is forced to win.
REQ-005 SHALL have port clk_i  input  1  clock; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req_valid_i  input  N_PORTS  per-port command valid.
REQ-008 SHALL have port req_op_i  input  2*N_PORTS  per-port op, res_op_t: SET, CHECK, CLR.
REQ-009 SHALL have port req_addr_i  input  AXI_ADDR_WIDTH*N_PORTS  per-port address.
REQ-010 SHALL have port req_id_i  input  AXI_ID_WIDTH*N_PORTS  per-port AXI ID.
REQ-011 SHALL have port req_ready_o  output  N_PORTS  per-port command accepted, i.e. gnt.
REQ-012 SHALL have port rsp_res_o  output  1  CHECK result, valid with req_ready_o of a CHECK.
REQ-013 SHALL have port tbl_valid_o / tbl_ready_i  output / input  1 / 1  table command handshake.
REQ-014 SHALL have port tbl_op_o, tbl_addr_o  output  2, AXI_ADDR_WIDTH  table command.
REQ-015 SHALL have port tbl_id_o  output  AXI_ID_WIDTH+$clog2(N_PORTS)  {port index, req_id}; N_PORTS=1 gives no index bits.
REQ-016 SHALL have port tbl_rsp_valid_i, tbl_res_i  input  1, 1  table CHECK result.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT_RSP.
REQ-018 IDLE: if any req_valid_i, SHALL latch grant index g and go to ISSUE next cycle; no output is asserted in IDLE.
REQ-019 Arbitration: SHALL pick a CLR over SET/CHECK, unless a starved port exists (REQ-022). SHALL use round-robin within the winning class, pointer = g+1 after each grant.
REQ-020 ISSUE: SHALL drive tbl_valid_o=1 with op/addr/id of port g, taken live from its inputs. On tbl_ready_i: for SET/CLR, pulse req_ready_o[g] the same cycle, then go to IDLE; for CHECK, go to WAIT_RSP.
REQ-021 WAIT_RSP: on tbl_rsp_valid_i, SHALL pulse req_ready_o[g]=1 and rsp_res_o=tbl_res_i the same cycle, then go to IDLE. tbl_rsp_valid_i SHALL be ignored in other states.
REQ-022 Per-port starvation counter: SHALL increment, saturating at STARVE_MAX, when the port has a valid SET/CHECK and loses arbitration. SHALL clear when the port is granted. A saturated port SHALL win over CLR, lowest index first.
REQ-023 Requesters SHALL hold valid/op/addr/id stable until req_ready_o; dropping valid before that is a protocol violation and need not be handled.
REQ-024 At most one table command SHALL be outstanding; throughput is one SET/CLR per 2 cycles with tbl_ready_i=1.
REQ-025 rsp_res_o SHALL be 0 whenever no CHECK is being acknowledged.
REQ-026 Stalls: tbl_valid_o and its command SHALL remain stable while tbl_ready_i=0.

Reset
REQ-027 On rst_ni low: state=IDLE, g=0, RR pointer=0, counters=0; all outputs low.
REQ-028 Reset mid-ISSUE/WAIT_RSP SHALL abandon the command without acking it; the table SHALL share rst_ni.

Structure
REQ-029 SHALL place res_op_t (SET=2'b00, CHECK=2'b01, CLR=2'b10) in shared package axi_res_pkg, also used by the table and adapters.
REQ-030 SHALL implement round-robin/priority selection as one sub-module, axi_res_rr_pick (N-bit request, class mask, pointer in; index out).

Verification
REQ-031 Single CHECK port0 addr 0x100 id 3, tbl_ready_i=1, rsp 1 cycle later with res=1 -> tbl_id_o={0,3}; req_ready_o[0] and rsp_res_o=1 in the same cycle, 3 cycles after valid.
REQ-032 Port0 SET and port1 CLR valid in the same cycle -> CLR issued first, then SET; port0 counter=1 after the first grant.
REQ-033 Port1 issues back-to-back CLRs, port0 holds SET, STARVE_MAX=4 -> port0 granted by the 5th arbitration.
REQ-034 tbl_ready_i held 0 for 10 cycles in ISSUE -> tbl_valid_o/addr/op stable throughout; no req_ready_o.
REQ-035 Reset asserted in WAIT_RSP -> all outputs 0 asynchronously; after release, a CHECK from port1 completes normally.
REQ-036 Spurious tbl_rsp_valid_i in IDLE -> no req_ready_o, state unchanged.
